// File: rtl/ifu_fetch_buf_pkg.sv
// Shared IF->ID definitions: zip layout and entry payload used by the fetch buffer and ID.
package ifu_fetch_buf_pkg;

    localparam int unsigned IF2ID_LEN    = 65;
    localparam int unsigned ZIP_PC_LSB   = 0;
    localparam int unsigned ZIP_INST_LSB = 32;
    localparam int unsigned ZIP_ADEF_BIT = 64;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } if2id_zip_t;

endpackage

// File: rtl/ifu_ibuf.sv
// In-order fetch entry FIFO: allocate at tail, fill the oldest unfilled entry, pop at head.
module ifu_ibuf
    import ifu_fetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             alloc,
    input  logic             alloc_adef,
    input  logic [31:0]      alloc_pc,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    input  logic             pop,
    output logic             full_c,
    output logic             head_vld_c,
    output if2id_zip_t       head_c,
    output logic [CNT_W-1:0] pend_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    if2id_zip_t       ent_q [DEPTH];
    if2id_zip_t       ent_d [DEPTH];
    logic [PTR_W-1:0] fill_idx;
    logic             fill_en;

    // Filled entries always precede unfilled ones, so the oldest unfilled sits right after them.
    assign fill_idx = head_q + PTR_W'(count_q - pend_q);
    assign fill_en  = fill && (pend_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pend_d  = pend_q;
        ent_d   = ent_q;
        if (alloc) begin
            ent_d[tail_q] = '{adef: alloc_adef, inst: 32'h0, pc: alloc_pc};
            tail_d        = tail_q + PTR_W'(1);
        end
        if (fill_en) begin
            ent_d[fill_idx].inst = fill_data;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
        pend_d  = pend_q + CNT_W'(alloc && !alloc_adef) - CNT_W'(fill_en);
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign head_vld_c = (count_q != pend_q);
    assign head_c     = ent_q[head_q];
    assign pend_cnt   = pend_q;

endmodule

// File: rtl/ifu_fetch_buf.sv
// Instruction fetch stage: PC generation, redirect cancellation of in-flight responses, ADEF handling.
module ifu_fetch_buf
    import ifu_fetch_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [31:0]          flush_target,
    input  logic                 br_taken,
    input  logic [31:0]          br_target,
    output logic                 inst_req,
    output logic [31:0]          inst_addr,
    input  logic                 inst_addr_ok,
    input  logic                 inst_data_ok,
    input  logic [31:0]          inst_rdata,
    input  logic                 id_allowin,
    output logic                 if_to_id_valid,
    output logic [IF2ID_LEN-1:0] if_to_id_zip
);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] cancel_q, cancel_d;
    logic             adef_pend_q, adef_pend_d;

    logic             redirect;
    logic             pc_misalign;
    logic             hs;
    logic             adef_alloc;
    logic             fill;
    logic             pop;
    logic             full;
    logic             head_vld;
    logic [CNT_W-1:0] pend_cnt;
    if2id_zip_t       head;

    assign redirect    = flush | br_taken;
    assign pc_misalign = (fetch_pc_q[1:0] != 2'b00);
    assign inst_req    = resetn & ~full & ~pc_misalign & ~adef_pend_q & ~redirect;
    assign inst_addr   = fetch_pc_q;
    assign hs          = inst_req & inst_addr_ok;
    assign adef_alloc  = resetn & ~full & pc_misalign & ~adef_pend_q & ~redirect;
    assign fill        = inst_data_ok & (cancel_q == '0) & ~redirect;

    assign if_to_id_valid = resetn & head_vld;
    assign pop            = if_to_id_valid & id_allowin;
    assign if_to_id_zip   = head;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        cancel_d    = cancel_q;
        adef_pend_d = adef_pend_q;
        if (flush) begin
            fetch_pc_d = flush_target;
        end else if (br_taken) begin
            fetch_pc_d = br_target;
        end else if (hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        // A redirect orphans every unfilled entry; a response landing this cycle is already one of them.
        if (redirect) begin
            adef_pend_d = 1'b0;
            if (cancel_q != '0) begin
                cancel_d = cancel_q - CNT_W'(inst_data_ok) + pend_cnt;
            end else if (inst_data_ok && (pend_cnt != '0)) begin
                cancel_d = pend_cnt - CNT_W'(1);
            end else begin
                cancel_d = pend_cnt;
            end
        end else begin
            if (adef_alloc) begin
                adef_pend_d = 1'b1;
            end
            if (inst_data_ok && (cancel_q != '0)) begin
                cancel_d = cancel_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q  <= RESET_PC;
            cancel_q    <= '0;
            adef_pend_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            cancel_q    <= cancel_d;
            adef_pend_q <= adef_pend_d;
        end
    end

    ifu_ibuf #(
        .DEPTH (IBUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_ibuf (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (redirect),
        .alloc      (hs | adef_alloc),
        .alloc_adef (adef_alloc),
        .alloc_pc   (fetch_pc_q),
        .fill       (fill),
        .fill_data  (inst_rdata),
        .pop        (pop),
        .full_c     (full),
        .head_vld_c (head_vld),
        .head_c     (head),
        .pend_cnt   (pend_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Scoreboard bench for ifu_fetch_buf: in-order bus model, expected-delivery queue and monitor.
module tb_ifu_fetch_buf;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [64:0] if_to_id_zip;

    logic        data_en;
    int          checks;
    int          errors;
    int          cyc;
    logic [64:0] exp_q [$];
    logic [31:0] bus_q [$];
    logic [31:0] hs_addr [$];
    int          hs_cyc [$];
    int          dlv_cyc [$];

    ifu_fetch_buf #(
        .RESET_PC   (RST_PC),
        .IBUF_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .flush_target   (flush_target),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_zip   (if_to_id_zip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic adef);
        exp_q.push_back({adef, (adef ? 32'h0 : rdata_of(pc)), pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // In-order bus: responds one cycle after acceptance at the earliest, reset with the core.
    initial begin
        logic        cap_rst;
        logic        cap_hs;
        logic        cap_dok;
        logic [31:0] cap_addr;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            cap_rst  = (resetn !== 1'b1);
            cap_hs   = (resetn === 1'b1) && (inst_req === 1'b1) && inst_addr_ok;
            cap_dok  = inst_data_ok;
            cap_addr = inst_addr;
            if (cap_hs) begin
                hs_addr.push_back(cap_addr);
                hs_cyc.push_back(cyc);
            end
            @(posedge clk);
            #2;
            if (cap_rst) begin
                bus_q.delete();
            end else begin
                if (cap_dok && bus_q.size() != 0) void'(bus_q.pop_front());
                if (cap_hs) bus_q.push_back(cap_addr);
            end
            inst_data_ok = data_en && resetn && (bus_q.size() != 0);
            inst_rdata   = (bus_q.size() != 0) ? rdata_of(bus_q[0]) : 32'h0;
        end
    end

    // Monitor: every ID handshake must match the oldest expected delivery.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && if_to_id_valid === 1'b1 && id_allowin === 1'b1) begin
                dlv_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery got %h expected none", if_to_id_zip);
                end else begin
                    e = exp_q.pop_front();
                    chk("delivery", if_to_id_zip, e);
                end
            end
        end
    end

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk(nm, 65'(exp_q.size()), 65'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        inst_addr_ok = 1'b0;
        flush        = 1'b0;
        br_taken     = 1'b0;
        flush_target = 32'h0;
        br_target    = 32'h0;
        id_allowin   = 1'b0;
        data_en      = 1'b0;
        step();
        sample();
        chk("rst_inst_req", 65'(inst_req), 65'd0);
        chk("rst_valid", 65'(if_to_id_valid), 65'd0);
        chk("rst_addr", 65'(inst_addr), 65'(RST_PC));
        step();
        resetn = 1'b1;
        hs_addr.delete();
        hs_cyc.delete();
        dlv_cyc.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        data_en = 1'b0;
        inst_addr_ok = 1'b0;
        id_allowin = 1'b0;
        flush = 1'b0;
        br_taken = 1'b0;
        flush_target = 32'h0;
        br_target = 32'h0;

        // Streaming fetch with single-cycle bus: order, latency, throughput, pointer wrap
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(RST_PC + 32'(4 * i), 1'b0);
        inst_addr_ok = 1'b1;
        id_allowin   = 1'b1;
        data_en      = 1'b1;
        repeat (6) step();
        inst_addr_ok = 1'b0;
        wait_drain("a_drain");
        chk("a_hs_count", 65'(hs_addr.size()), 65'd6);
        for (int i = 0; i < 3; i++) begin
            if (hs_addr.size() > i) chk("a_hs_addr", 65'(hs_addr[i]), 65'(RST_PC + 32'(4 * i)));
        end
        chk("a_hs_consec", 65'((hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[0] : -1), 65'd2);
        chk("a_latency", 65'((dlv_cyc.size() > 0 && hs_cyc.size() > 0) ? dlv_cyc[0] - hs_cyc[0] : -1), 65'd2);
        chk("a_thruput", 65'((dlv_cyc.size() >= 6) ? dlv_cyc[5] - dlv_cyc[0] : -1), 65'd5);
        sample();
        chk("a_next_addr", 65'(inst_addr), 65'h1c00_0018);

        // ID stalled: buffer fills after exactly four handshakes and fetch_pc holds
        do_reset();
        inst_addr_ok = 1'b1;
        data_en      = 1'b1;
        repeat (8) step();
        sample();
        chk("b_hs_count", 65'(hs_addr.size()), 65'd4);
        chk("b_full_req", 65'(inst_req), 65'd0);
        chk("b_full_addr", 65'(inst_addr), 65'h1c00_0010);
        step();
        inst_addr_ok = 1'b0;
        id_allowin   = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(RST_PC + 32'(4 * i), 1'b0);
        wait_drain("b_drain");

        // Branch with two responses in flight: both discarded, new target delivered first
        do_reset();
        push_exp(32'h1c00_0100, 1'b0);
        push_exp(32'h1c00_0104, 1'b0);
        id_allowin   = 1'b1;
        inst_addr_ok = 1'b1;
        step();
        step();
        inst_addr_ok = 1'b0;
        br_taken     = 1'b1;
        br_target    = 32'h1c00_0100;
        sample();
        chk("c_redir_req", 65'(inst_req), 65'd0);
        step();
        br_taken     = 1'b0;
        inst_addr_ok = 1'b1;
        data_en      = 1'b1;
        sample();
        chk("c_resume_req", 65'(inst_req), 65'd1);
        chk("c_resume_addr", 65'(inst_addr), 65'h1c00_0100);
        step();
        step();
        inst_addr_ok = 1'b0;
        wait_drain("c_drain");
        chk("c_hs_count", 65'(hs_addr.size()), 65'd4);

        // Misaligned flush target: one ADEF entry, fetch halted until the next branch
        do_reset();
        push_exp(32'h1c00_0102, 1'b1);
        id_allowin   = 1'b1;
        inst_addr_ok = 1'b1;
        data_en      = 1'b1;
        flush        = 1'b1;
        flush_target = 32'h1c00_0102;
        sample();
        chk("d_flush_req", 65'(inst_req), 65'd0);
        step();
        flush = 1'b0;
        sample();
        chk("d_adef_req", 65'(inst_req), 65'd0);
        chk("d_adef_addr", 65'(inst_addr), 65'h1c00_0102);
        repeat (4) step();
        sample();
        chk("d_halt_req", 65'(inst_req), 65'd0);
        chk("d_hs_count", 65'(hs_addr.size()), 65'd0);
        wait_drain("d_drain");
        inst_addr_ok = 1'b0;
        br_taken     = 1'b1;
        br_target    = 32'h1c00_0200;
        step();
        br_taken = 1'b0;
        sample();
        chk("d_br_req", 65'(inst_req), 65'd1);
        chk("d_br_addr", 65'(inst_addr), 65'h1c00_0200);

        // Flush and branch together while a response lands: flush wins, cancel = unfilled-1
        do_reset();
        push_exp(32'h1c00_0300, 1'b0);
        push_exp(32'h1c00_0304, 1'b0);
        id_allowin   = 1'b1;
        inst_addr_ok = 1'b1;
        repeat (3) step();
        inst_addr_ok = 1'b0;
        data_en      = 1'b1;
        flush        = 1'b1;
        br_taken     = 1'b1;
        flush_target = 32'h1c00_0300;
        br_target    = 32'h1c00_0400;
        step();
        flush        = 1'b0;
        br_taken     = 1'b0;
        inst_addr_ok = 1'b1;
        sample();
        chk("e_target_addr", 65'(inst_addr), 65'h1c00_0300);
        chk("e_resume_req", 65'(inst_req), 65'd1);
        step();
        step();
        inst_addr_ok = 1'b0;
        wait_drain("e_drain");

        // Reset mid-transaction with a pending cancel: nothing carries over
        do_reset();
        id_allowin   = 1'b1;
        inst_addr_ok = 1'b1;
        step();
        step();
        inst_addr_ok = 1'b0;
        br_taken     = 1'b1;
        br_target    = 32'h1c00_0500;
        step();
        br_taken = 1'b0;
        resetn   = 1'b0;
        step();
        resetn = 1'b1;
        sample();
        chk("f_valid", 65'(if_to_id_valid), 65'd0);
        chk("f_addr", 65'(inst_addr), 65'(RST_PC));
        chk("f_req", 65'(inst_req), 65'd1);
        step();
        push_exp(RST_PC, 1'b0);
        push_exp(RST_PC + 32'd4, 1'b0);
        inst_addr_ok = 1'b1;
        data_en      = 1'b1;
        step();
        step();
        inst_addr_ok = 1'b0;
        wait_drain("f_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
